// File: rtl/soc_sysid_checker.sv
// Boot-time system-ID checker: reads the ID and build-timestamp words over Avalon-MM,
// retries on mismatch or stall timeout, and reports a single pass/fail verdict.
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempts
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    MAX_ATT  = 5'(MAX_RETRIES);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          auto_pend_q, auto_pend_d;
    logic          avm_address_q, avm_address_d;
    logic          avm_read_q, avm_read_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          id_ok_q, id_ok_d;
    logic          ts_ok_q, ts_ok_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   id_value_q, id_value_d;
    logic [31:0]   ts_value_q, ts_value_d;
    logic [3:0]    attempts_q, attempts_d;

    logic          launch;
    logic          accept;
    logic          id_match;
    logic          ts_match;

    assign accept   = avm_read_q && !avm_waitrequest;
    assign id_match = (id_value_q == EXPECTED_ID) && !timeout_err_q;
    assign ts_match = CHECK_TS ? ((ts_value_q == EXPECTED_TS) && !timeout_err_q) : 1'b1;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        auto_pend_d   = 1'b0;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_err_d = timeout_err_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        attempts_d    = attempts_q;
        launch        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // auto_pend_q is only ever set in the first cycle after reset (state IDLE)
                launch = start || auto_pend_q;
            end
            S_RD_ID: begin
                if (accept) begin
                    id_value_d = avm_readdata;
                    timer_d    = '0;
                    state_d    = S_RD_TS;
                end else if (timer_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_TS: begin
                if (accept) begin
                    ts_value_d = avm_readdata;
                    state_d    = S_CHECK;
                end else if (timer_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                id_ok_d = id_match;
                ts_ok_d = ts_match;
                if (id_match && ts_match) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if ({1'b0, attempts_q} <= MAX_ATT) begin
                    attempts_d    = (attempts_q == 4'hf) ? 4'hf : attempts_q + 4'd1;
                    timeout_err_d = 1'b0;
                    id_value_d    = '0;
                    ts_value_d    = '0;
                    timer_d       = '0;
                    state_d       = S_RD_ID;
                end else begin
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            done_d        = 1'b0;
            pass_d        = 1'b0;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
            timeout_err_d = 1'b0;
            id_value_d    = '0;
            ts_value_d    = '0;
            attempts_d    = 4'd1;
            busy_d        = 1'b1;
            timer_d       = '0;
            state_d       = S_RD_ID;
        end

        // Bus outputs are registered, so they are decoded from the next state
        avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        avm_address_d = (state_d == S_RD_TS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            auto_pend_q   <= AUTO_START;
            avm_address_q <= 1'b0;
            avm_read_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
            attempts_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            auto_pend_q   <= auto_pend_d;
            avm_address_q <= avm_address_d;
            avm_read_q    <= avm_read_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_err_q <= timeout_err_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
            attempts_q    <= attempts_d;
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = timeout_err_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign attempts    = attempts_q;

endmodule
